// File: rtl/sequence_detector.sv
// Checks debounced single-key presses against a stored 2-bit colour sequence.
// Reports correct/gameOver levels for the game FSM; all outputs are registered.
module sequence_detector #(
  parameter int MAX_LEN         = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   startReading,
  input  logic [3:0]             sequenceSize,
  input  logic [2*MAX_LEN-1:0]   pattern,
  input  logic [3:0]             keys,
  output logic                   correct,
  output logic                   gameOver,
  output logic                   pressAccepted,
  output logic [1:0]             currentKey,
  output logic [3:0]             inputIndex
);

  localparam int DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = (DEBOUNCE_CYCLES > 0) ? DW'(DEBOUNCE_CYCLES - 1) : '0;
  localparam logic [31:0]   TLAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [3:0]    MAXL  = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, WAITPRESS, DEBOUNCE, WAITRELEASE, CORRECT, WRONG
  } state_t;

  state_t          r_state, w_state;
  logic [3:0]      r_size, w_size;
  logic [3:0]      r_idx, w_idx;
  logic [31:0]     r_tcnt, w_tcnt;
  logic [DW-1:0]   r_dcnt, w_dcnt;
  logic [3:0]      r_cap_keys, w_cap_keys;
  logic [1:0]      r_cap_code, w_cap_code;
  logic            r_correct, w_correct;
  logic            r_gameover, w_gameover;
  logic            r_pa, w_pa;
  logic [1:0]      r_curkey, w_curkey;

  logic            w_onehot;
  logic [1:0]      w_code;
  logic [1:0]      w_expected;
  logic [3:0]      w_size_clamped;

  assign w_onehot       = (keys != 4'd0) && ((keys & (keys - 4'd1)) == 4'd0);
  assign w_expected     = pattern[{r_idx, 1'b0} +: 2];
  assign w_size_clamped = (sequenceSize > MAXL) ? MAXL : sequenceSize;

  always_comb begin
    w_code = 2'd0;
    case (keys)
      4'b0010: w_code = 2'd1;
      4'b0100: w_code = 2'd2;
      4'b1000: w_code = 2'd3;
      default: w_code = 2'd0;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_size     = r_size;
    w_idx      = r_idx;
    w_tcnt     = r_tcnt;
    w_dcnt     = r_dcnt;
    w_cap_keys = r_cap_keys;
    w_cap_code = r_cap_code;
    w_correct  = r_correct;
    w_gameover = r_gameover;
    w_pa       = 1'b0;
    w_curkey   = r_curkey;
    if (startReading) begin
      w_state    = IDLE;
      w_idx      = 4'd0;
      w_tcnt     = 32'd0;
      w_dcnt     = '0;
      w_correct  = 1'b0;
      w_gameover = 1'b0;
      w_curkey   = 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_size = w_size_clamped;
          if (w_size_clamped == 4'd0) begin
            w_state   = CORRECT;
            w_correct = 1'b1;
          end else begin
            w_state = WAITPRESS;
            w_idx   = 4'd0;
            w_tcnt  = 32'd0;
          end
        end
        WAITPRESS: begin
          w_tcnt = r_tcnt + 32'd1;
          if (w_onehot) begin
            w_cap_keys = keys;
            w_cap_code = w_code;
            w_dcnt     = '0;
            w_state    = DEBOUNCE;
          end else if (TIMEOUT_CYCLES != 0 && r_tcnt == TLAST) begin
            w_state    = WRONG;
            w_gameover = 1'b1;
          end
        end
        DEBOUNCE: begin
          // A bounce returns to WAITPRESS without resetting the idle timeout.
          if (keys != r_cap_keys) begin
            w_state = WAITPRESS;
          end else if (r_dcnt == DLAST) begin
            w_curkey = r_cap_code;
            if (r_cap_code == w_expected) begin
              w_pa    = 1'b1;
              w_state = WAITRELEASE;
            end else begin
              w_gameover = 1'b1;
              w_state    = WRONG;
            end
          end else begin
            w_dcnt = r_dcnt + 1'b1;
          end
        end
        WAITRELEASE: begin
          if (keys == 4'd0) begin
            if (r_idx == r_size - 4'd1) begin
              w_state   = CORRECT;
              w_correct = 1'b1;
            end else begin
              w_idx   = r_idx + 4'd1;
              w_tcnt  = 32'd0;
              w_state = WAITPRESS;
            end
          end
        end
        CORRECT: w_state = CORRECT;
        WRONG:   w_state = WRONG;
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_size     <= 4'd0;
      r_idx      <= 4'd0;
      r_tcnt     <= 32'd0;
      r_dcnt     <= '0;
      r_cap_keys <= 4'd0;
      r_cap_code <= 2'd0;
      r_correct  <= 1'b0;
      r_gameover <= 1'b0;
      r_pa       <= 1'b0;
      r_curkey   <= 2'd0;
    end else begin
      r_state    <= w_state;
      r_size     <= w_size;
      r_idx      <= w_idx;
      r_tcnt     <= w_tcnt;
      r_dcnt     <= w_dcnt;
      r_cap_keys <= w_cap_keys;
      r_cap_code <= w_cap_code;
      r_correct  <= w_correct;
      r_gameover <= w_gameover;
      r_pa       <= w_pa;
      r_curkey   <= w_curkey;
    end
  end

  assign correct       = r_correct;
  assign gameOver      = r_gameover;
  assign pressAccepted = r_pa;
  assign currentKey    = r_curkey;
  assign inputIndex    = r_idx;

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector with short debounce/timeout parameters.
module tb_sequence_detector;
  logic        clk = 1'b0;
  logic        rst;
  logic        startReading;
  logic [3:0]  sequenceSize;
  logic [19:0] pattern;
  logic [3:0]  keys;
  logic        correct, gameOver, pressAccepted;
  logic [1:0]  currentKey;
  logic [3:0]  inputIndex;

  int total = 0;
  int bad   = 0;
  int pcnt  = 0;
  int psnap;

  sequence_detector #(.MAX_LEN(10), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50(clk), .reset(rst), .startReading(startReading), .sequenceSize(sequenceSize),
    .pattern(pattern), .keys(keys), .correct(correct), .gameOver(gameOver),
    .pressAccepted(pressAccepted), .currentKey(currentKey), .inputIndex(inputIndex)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pressAccepted === 1'b1) pcnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".correct"}, 32'(correct), 0);
    chk({tag, ".gameOver"}, 32'(gameOver), 0);
    chk({tag, ".pa"}, 32'(pressAccepted), 0);
    chk({tag, ".curkey"}, 32'(currentKey), 0);
    chk({tag, ".index"}, 32'(inputIndex), 0);
  endtask

  // Holds k for 6 cycles; the accept pulse is due on the 5th.
  task automatic press_ok(input logic [3:0] k, input logic [1:0] code, input string tag);
    keys = k;
    repeat (4) @(negedge clk);
    chk({tag, ".early"}, 32'(pressAccepted), 0);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(pressAccepted), 1);
    chk({tag, ".curkey"}, 32'(currentKey), 32'(code));
    @(negedge clk);
    chk({tag, ".pulse_end"}, 32'(pressAccepted), 0);
  endtask

  task automatic release_keys();
    keys = 4'd0;
    @(negedge clk);
  endtask

  task automatic restart();
    startReading = 1'b1;
    @(negedge clk);
    startReading = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; startReading = 1'b1; sequenceSize = 4'd3; keys = 4'd0;
    pattern = 20'h00032;  // entries 2,0,3
    #2;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("hold_start");

    // 1: full correct sequence
    startReading = 1'b0;
    @(negedge clk);
    chk("t1.idx0", 32'(inputIndex), 0);
    press_ok(4'b0100, 2'd2, "t1.p0"); release_keys();
    chk("t1.idx1", 32'(inputIndex), 1);
    press_ok(4'b0001, 2'd0, "t1.p1"); release_keys();
    chk("t1.idx2", 32'(inputIndex), 2);
    press_ok(4'b1000, 2'd3, "t1.p2");
    keys = 4'd0;
    chk("t1.pre_correct", 32'(correct), 0);
    @(negedge clk);
    chk("t1.correct", 32'(correct), 1);
    chk("t1.gameover", 32'(gameOver), 0);
    chk("t1.pulses", 32'(pcnt), 3);

    // 2: wrong key on 2nd entry
    startReading = 1'b1;
    @(negedge clk);
    chk_all_zero("t2.clear");
    startReading = 1'b0;
    @(negedge clk);
    press_ok(4'b0100, 2'd2, "t2.p0"); release_keys();
    psnap = pcnt;
    keys = 4'b0010;
    repeat (5) @(negedge clk);
    chk("t2.gameover", 32'(gameOver), 1);
    chk("t2.curkey", 32'(currentKey), 1);
    chk("t2.index", 32'(inputIndex), 1);
    chk("t2.correct", 32'(correct), 0);
    chk("t2.nopulse", 32'(pcnt), 32'(psnap));
    keys = 4'd0;

    // 3: glitch, two-key press, timeout
    restart();
    psnap = pcnt;
    keys = 4'b0100; @(negedge clk);
    keys = 4'b0000; repeat (6) @(negedge clk);
    chk("t3.glitch", 32'(pcnt), 32'(psnap));
    keys = 4'b0101; repeat (8) @(negedge clk);
    chk("t3.twokey", 32'(pcnt), 32'(psnap));
    chk("t3.twokey_go", 32'(gameOver), 0);
    keys = 4'd0;
    restart();
    repeat (99) @(negedge clk);
    chk("t3.pre_timeout", 32'(gameOver), 0);
    @(negedge clk);
    chk("t3.timeout", 32'(gameOver), 1);
    chk("t3.timeout_corr", 32'(correct), 0);

    // 4: abort in WAITRELEASE
    restart();
    press_ok(4'b0100, 2'd2, "t4.p0"); release_keys();
    press_ok(4'b0001, 2'd0, "t4.p1"); release_keys();
    press_ok(4'b1000, 2'd3, "t4.p2");
    chk("t4.idx_before", 32'(inputIndex), 2);
    startReading = 1'b1;
    @(negedge clk);
    chk_all_zero("t4.abort");
    keys = 4'd0;
    startReading = 1'b0;
    @(negedge clk);
    press_ok(4'b0100, 2'd2, "t4.re_p0");
    chk("t4.re_idx0", 32'(inputIndex), 0);
    release_keys();
    chk("t4.re_idx1", 32'(inputIndex), 1);

    // 5: size 0 and clamped size 15
    startReading = 1'b1;
    sequenceSize = 4'd0;
    @(negedge clk);
    startReading = 1'b0;
    chk("t5.size0_pre", 32'(correct), 0);
    @(negedge clk);
    chk("t5.size0", 32'(correct), 1);
    chk("t5.size0_go", 32'(gameOver), 0);
    startReading = 1'b1;
    sequenceSize = 4'd15;
    pattern = 20'h4E4E4;  // entry i = i % 4
    @(negedge clk);
    startReading = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      press_ok(4'b0001 << (i % 4), 2'(i % 4), $sformatf("t5.p%0d", i));
      release_keys();
      if (i < 9) begin
        chk($sformatf("t5.idx%0d", i + 1), 32'(inputIndex), 32'(i + 1));
        chk($sformatf("t5.notdone%0d", i), 32'(correct), 0);
      end
    end
    chk("t5.correct10", 32'(correct), 1);
    chk("t5.go10", 32'(gameOver), 0);

    // 6: async reset during DEBOUNCE
    restart();
    press_ok(4'b0001, 2'd0, "t6.p0"); release_keys();
    chk("t6.idx1", 32'(inputIndex), 1);
    keys = 4'b0010;
    @(negedge clk);
    #2 rst = 1'b1; startReading = 1'b1;
    #1;
    chk_all_zero("t6.async");
    #1 rst = 1'b0;
    psnap = pcnt;
    repeat (10) @(negedge clk);
    chk("t6.held_nopulse", 32'(pcnt), 32'(psnap));
    chk("t6.held_idx", 32'(inputIndex), 0);
    startReading = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6.go", 32'(gameOver), 1);
    chk("t6.curkey", 32'(currentKey), 1);
    chk("t6.nopulse", 32'(pcnt), 32'(psnap));
    keys = 4'd0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
